status_blink_encoder: RTL and testbench

//  Status-LED blink encoder sitting upstream of the board LED pins.
//  - Accepts a numeric status code over a valid/ready handshake.
//  - Renders it as N visible blinks followed by a dark gap, so the board reports state by blink count.
//  - Also drives a free-running heartbeat LED that shows the fabric clock is alive.

---
 rtl/status_blink_encoder.sv | 161 ++++++++++++++++
 tb/tb_status_blink_encoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/status_blink_encoder.sv
// Status-LED blink encoder: shows an accepted status code as N blinks plus a dark gap,
// and runs an independent heartbeat toggle so a live fabric clock is visible.
module status_blink_encoder #(
  parameter int unsigned CLK_FREQ  = 25000000,
  parameter int unsigned TICK_DIV  = 2500000,
  parameter int unsigned ON_TICKS  = 2,
  parameter int unsigned OFF_TICKS = 3,
  parameter int unsigned GAP_TICKS = 10,
  parameter int unsigned HB_CYCLES = 37500000,
  parameter int unsigned CODE_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code,
  output logic              code_ready,
  output logic              busy,
  output logic              led_blink,
  output logic              heartbeat
);

  localparam int unsigned PH_MAX =
    (ON_TICKS > OFF_TICKS) ? ((ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS)
                           : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
  localparam int unsigned PS_W = $clog2(TICK_DIV);
  localparam int unsigned PH_W = $clog2(PH_MAX + 1);
  localparam int unsigned HB_W = $clog2(HB_CYCLES);

  localparam logic [PS_W-1:0] TICK_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0] ON_LAST   = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0] OFF_LAST  = PH_W'(OFF_TICKS - 1);
  localparam logic [PH_W-1:0] GAP_LAST  = PH_W'(GAP_TICKS - 1);
  localparam logic [HB_W-1:0] HB_LAST   = HB_W'(HB_CYCLES - 1);

  if (CLK_FREQ == 0 || TICK_DIV < 2 || ON_TICKS < 1 || OFF_TICKS < 1 ||
      GAP_TICKS < 1 || HB_CYCLES < 2 || CODE_W < 1) begin : g_bad_params
    $error("status_blink_encoder: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ON,
    ST_OFF,
    ST_GAP
  } state_e;

  state_e            state_q;
  logic [CODE_W-1:0] remaining_q;
  logic [PS_W-1:0]   prescaler_q;
  logic [PH_W-1:0]   phase_cnt_q;
  logic              led_q;
  logic [HB_W-1:0]   hb_cnt_q, hb_cnt_d;
  logic              hb_q, hb_d;

  logic tick;

  assign tick       = (prescaler_q == TICK_LAST);
  assign code_ready = (state_q == ST_IDLE);
  assign busy       = ~code_ready;
  assign led_blink  = led_q;
  assign heartbeat  = hb_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      prescaler_q <= '0;
      phase_cnt_q <= '0;
      led_q       <= 1'b0;
    end else begin
      if (state_q != ST_IDLE) begin
        prescaler_q <= tick ? '0 : prescaler_q + 1'b1;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (code_valid) begin
            // Restarting the prescaler makes every phase an exact multiple of TICK_DIV.
            prescaler_q <= '0;
            phase_cnt_q <= '0;
            remaining_q <= code;
            if (code != '0) begin
              state_q <= ST_ON;
              led_q   <= 1'b1;
            end else begin
              state_q <= ST_GAP;
            end
          end
        end

        ST_ON: begin
          if (tick) begin
            if (phase_cnt_q == ON_LAST) begin
              state_q     <= ST_OFF;
              led_q       <= 1'b0;
              phase_cnt_q <= '0;
              remaining_q <= remaining_q - 1'b1;
            end else begin
              phase_cnt_q <= phase_cnt_q + 1'b1;
            end
          end
        end

        ST_OFF: begin
          if (tick) begin
            if (phase_cnt_q == OFF_LAST) begin
              phase_cnt_q <= '0;
              if (remaining_q != '0) begin
                state_q <= ST_ON;
                led_q   <= 1'b1;
              end else begin
                state_q <= ST_GAP;
              end
            end else begin
              phase_cnt_q <= phase_cnt_q + 1'b1;
            end
          end
        end

        ST_GAP: begin
          if (tick) begin
            if (phase_cnt_q == GAP_LAST) begin
              state_q     <= ST_IDLE;
              phase_cnt_q <= '0;
            end else begin
              phase_cnt_q <= phase_cnt_q + 1'b1;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          led_q   <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: next-state values are assigned a default first so no path infers a latch.
  always_comb begin
    hb_cnt_d = hb_cnt_q + 1'b1;
    hb_d     = hb_q;
    if (hb_cnt_q == HB_LAST) begin
      hb_cnt_d = '0;
      hb_d     = ~hb_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
    end
  end

endmodule

// File: tb/tb_status_blink_encoder.sv
// Self-checking bench for status_blink_encoder: randomised codes compared cycle by cycle
// against a waveform model derived from the blink timing rules.
module tb_status_blink_encoder;

  localparam int TD      = 4;
  localparam int ONT     = 2;
  localparam int OFFT    = 3;
  localparam int GAPT    = 5;
  localparam int HB      = 6;
  localparam int CW      = 4;
  localparam int ON_CYC  = ONT * TD;
  localparam int BLINK   = (ONT + OFFT) * TD;
  localparam int GAP_CYC = GAPT * TD;

  logic          clk = 1'b0;
  logic          rst;
  logic          code_valid;
  logic [CW-1:0] code;
  logic          code_ready;
  logic          busy;
  logic          led_blink;
  logic          heartbeat;

  int n_checks = 0;
  int n_pass   = 0;
  int hb_cyc   = 0;

  always #5 clk = ~clk;

  status_blink_encoder #(
    .CLK_FREQ (25000000),
    .TICK_DIV (TD),
    .ON_TICKS (ONT),
    .OFF_TICKS(OFFT),
    .GAP_TICKS(GAPT),
    .HB_CYCLES(HB),
    .CODE_W   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .code_valid(code_valid),
    .code      (code),
    .code_ready(code_ready),
    .busy      (busy),
    .led_blink (led_blink),
    .heartbeat (heartbeat)
  );

  // Clock edges seen since reset was last released.
  always @(posedge clk or posedge rst) begin
    if (rst) hb_cyc <= 0;
    else     hb_cyc <= hb_cyc + 1;
  end

  function automatic int seq_len(input int n);
    return n * BLINK + GAP_CYC;
  endfunction

  // Expected {code_ready, busy, led_blink, heartbeat} k cycles after accepting code n.
  function automatic logic [3:0] exp_vec(input int n, input int k);
    logic b, l, h;
    b = (k < seq_len(n));
    l = (n > 0) && (k < n * BLINK) && ((k % BLINK) < ON_CYC);
    h = ((hb_cyc / HB) % 2) == 1;
    return {~b, b, l, h};
  endfunction

  // Waits (bounded) for ready, presents code n for one cycle; returns at the k=0 sample point.
  task automatic start_code(input int n);
    int w = 0;
    while (code_ready !== 1'b1 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (code_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL ready_timeout: code_ready=%b, required 1 within 1000 cycles", code_ready);
    end
    code_valid = 1'b1;
    code       = CW'(n);
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    rst = 1'b1;
    code_valid = 1'b0;
    code = '0;
    @(negedge clk);
    @(negedge clk);
    obs = {code_ready, busy, led_blink, heartbeat};
    n_checks++;
    if (obs !== 4'b1000) $display("FAIL reset_state: {rdy,busy,led,hb}=%b, required 1000", obs);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_code3();
    logic [3:0] obs, exp;
    start_code(3);
    for (int k = 0; k <= seq_len(3); k++) begin
      obs = {code_ready, busy, led_blink, heartbeat};
      exp = exp_vec(3, k);
      n_checks++;
      if (obs !== exp) $display("FAIL code3 k=%0d: {rdy,busy,led,hb}=%b, required %b", k, obs, exp);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_code0();
    logic [3:0] obs, exp;
    start_code(0);
    for (int k = 0; k <= seq_len(0); k++) begin
      obs = {code_ready, busy, led_blink, heartbeat};
      exp = exp_vec(0, k);
      n_checks++;
      if (obs !== exp) $display("FAIL code0 k=%0d: {rdy,busy,led,hb}=%b, required %b", k, obs, exp);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_code15();
    logic [3:0] obs, exp;
    start_code(15);
    for (int k = 0; k <= seq_len(15) + 2; k++) begin
      obs = {code_ready, busy, led_blink, heartbeat};
      exp = exp_vec(15, k);
      n_checks++;
      if (obs !== exp) $display("FAIL code15 k=%0d: {rdy,busy,led,hb}=%b, required %b", k, obs, exp);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_hold_valid();
    logic [3:0] obs, exp;
    code_valid = 1'b1;
    code       = CW'(1);
    @(negedge clk);
    code = CW'(2);
    for (int k = 0; k <= seq_len(1); k++) begin
      obs = {code_ready, busy, led_blink, heartbeat};
      exp = exp_vec(1, k);
      n_checks++;
      if (obs !== exp) $display("FAIL hold_first k=%0d: {rdy,busy,led,hb}=%b, required %b", k, obs, exp);
      else n_pass++;
      @(negedge clk);
    end
    code_valid = 1'b0;
    for (int k = 0; k <= seq_len(2); k++) begin
      obs = {code_ready, busy, led_blink, heartbeat};
      exp = exp_vec(2, k);
      n_checks++;
      if (obs !== exp) $display("FAIL hold_second k=%0d: {rdy,busy,led,hb}=%b, required %b", k, obs, exp);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] obs, exp;
    start_code(3);
    for (int k = 0; k < 22; k++) @(negedge clk);
    obs = {code_ready, busy, led_blink, heartbeat};
    exp = exp_vec(3, 22);
    n_checks++;
    if (obs !== exp) $display("FAIL mid_before_rst: {rdy,busy,led,hb}=%b, required %b", obs, exp);
    else n_pass++;
    #2 rst = 1'b1;
    #1;
    obs = {code_ready, busy, led_blink, heartbeat};
    n_checks++;
    if (obs !== 4'b1000) $display("FAIL mid_async_rst: {rdy,busy,led,hb}=%b, required 1000", obs);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    obs = {code_ready, busy, led_blink, heartbeat};
    n_checks++;
    if (obs !== 4'b1000) $display("FAIL mid_after_release: {rdy,busy,led,hb}=%b, required 1000", obs);
    else n_pass++;
    start_code(1);
    for (int k = 0; k <= seq_len(1); k++) begin
      obs = {code_ready, busy, led_blink, heartbeat};
      exp = exp_vec(1, k);
      n_checks++;
      if (obs !== exp) $display("FAIL mid_restart k=%0d: {rdy,busy,led,hb}=%b, required %b", k, obs, exp);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] obs, exp;
    int n, idle;
    for (int t = 0; t < 6; t++) begin
      n    = int'($urandom_range(0, 15));
      idle = int'($urandom_range(0, 3));
      for (int i = 0; i < idle; i++) @(negedge clk);
      start_code(n);
      for (int k = 0; k < seq_len(n); k++) begin
        obs = {code_ready, busy, led_blink, heartbeat};
        exp = exp_vec(n, k);
        n_checks++;
        if (obs !== exp) $display("FAIL rand%0d code=%0d k=%0d: {rdy,busy,led,hb}=%b, required %b",
                                  t, n, k, obs, exp);
        else n_pass++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_heartbeat();
    logic exp;
    for (int k = 0; k < 30; k++) begin
      exp = ((hb_cyc / HB) % 2) == 1;
      n_checks++;
      if (heartbeat !== exp) $display("FAIL heartbeat k=%0d: heartbeat=%b, required %b", k, heartbeat, exp);
      else n_pass++;
      if (k == 7) begin
        code_valid = 1'b1;
        code       = CW'($urandom_range(1, 15));
      end else begin
        code_valid = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_code3();
    test_code0();
    test_code15();
    test_hold_valid();
    test_reset_mid();
    test_back_to_back();
    test_heartbeat();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
